// File: rtl/btn_conditioner_if.sv
// Button-side bundle for btn_conditioner: raw pushbuttons in, conditioned mode/pulse and debug levels out.
// The board/bench side uses master; the conditioner uses slave.
interface btn_conditioner_if;
    logic btn_step;
    logic btn_mode;
    logic mode;
    logic pulse;
    logic step_db;
    logic mode_db;

    modport master (
        output btn_step,
        output btn_mode,
        input  mode,
        input  pulse,
        input  step_db,
        input  mode_db
    );

    modport slave (
        input  btn_step,
        input  btn_mode,
        output mode,
        output pulse,
        output step_db,
        output mode_db
    );
endinterface

// File: rtl/btn_conditioner.sv
// Purpose: sync + debounce two pushbuttons; step gives a one-cycle pulse in manual mode, mode button toggles mode.
// Latency: raw first sampled at edge k and held -> accepted (db/mode/pulse update) at edge k+DEBOUNCE_CNT+1.
// Backpressure: none; free-running, every output is a register.
module btn_conditioner #(
    parameter int DEBOUNCE_CNT = 20000,
    parameter int CNT_W        = 15
) (
    input  logic             clk,
    input  logic             rst,
    btn_conditioner_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             step_s1, step_s2;
    logic             mode_s1, mode_s2;
    logic [CNT_W-1:0] step_cnt, mode_cnt;
    logic             step_db_q, mode_db_q;
    logic             mode_q, pulse_q;
    logic             step_acc, mode_acc;

    // Accept fires on the edge where the synced level has disagreed for DEBOUNCE_CNT cycles.
    assign step_acc = (step_s2 != step_db_q) && (step_cnt == CNT_MAX);
    assign mode_acc = (mode_s2 != mode_db_q) && (mode_cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            step_s1   <= 1'b0;
            step_s2   <= 1'b0;
            mode_s1   <= 1'b0;
            mode_s2   <= 1'b0;
            step_cnt  <= '0;
            mode_cnt  <= '0;
            step_db_q <= 1'b0;
            mode_db_q <= 1'b0;
            mode_q    <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            step_s1 <= bus.btn_step;
            step_s2 <= step_s1;
            mode_s1 <= bus.btn_mode;
            mode_s2 <= mode_s1;

            if (step_s2 == step_db_q) begin
                step_cnt <= '0;
            end else if (step_acc) begin
                step_db_q <= step_s2;
                step_cnt  <= '0;
            end else begin
                step_cnt <= step_cnt + CNT_ONE;
            end

            if (mode_s2 == mode_db_q) begin
                mode_cnt <= '0;
            end else if (mode_acc) begin
                mode_db_q <= mode_s2;
                mode_cnt  <= '0;
            end else begin
                mode_cnt <= mode_cnt + CNT_ONE;
            end

            // Pulse is gated by the mode value held before this edge, even if mode toggles now.
            pulse_q <= step_acc && step_s2 && mode_q;
            if (mode_acc && mode_s2) begin
                mode_q <= ~mode_q;
            end
        end
    end

    assign bus.mode    = mode_q;
    assign bus.pulse   = pulse_q;
    assign bus.step_db = step_db_q;
    assign bus.mode_db = mode_db_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner with DEBOUNCE_CNT=4: directed scenarios plus random glitchy buttons vs a window model.
module tb_btn_conditioner;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passed = 0;

    btn_conditioner_if bus();

    btn_conditioner #(.DEBOUNCE_CNT(N), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: raw samples of the last N+2 edges; a level is accepted when the
    // raw samples taken N+1..2 edges ago all differ from the current debounced level.
    bit hs [0:N+1];
    bit hm [0:N+1];
    bit e_sdb, e_mdb, e_mode, e_pulse;

    task automatic model_edge(input bit s, input bit m, input bit r);
        bit acc_s, acc_m;
        if (r) begin
            for (int i = 0; i <= N + 1; i++) begin
                hs[i] = 1'b0;
                hm[i] = 1'b0;
            end
            e_sdb = 0; e_mdb = 0; e_mode = 0; e_pulse = 0;
        end else begin
            acc_s = 1'b1;
            acc_m = 1'b1;
            for (int i = 1; i <= N; i++) begin
                if (hs[i] == e_sdb) acc_s = 1'b0;
                if (hm[i] == e_mdb) acc_m = 1'b0;
            end
            e_pulse = acc_s && !e_sdb && e_mode;
            if (acc_m && !e_mdb) e_mode = !e_mode;
            if (acc_s) e_sdb = !e_sdb;
            if (acc_m) e_mdb = !e_mdb;
            for (int i = 0; i <= N; i++) begin
                hs[i] = hs[i+1];
                hm[i] = hm[i+1];
            end
            hs[N+1] = s;
            hm[N+1] = m;
        end
    endtask

    // Drive at the negedge, let one posedge happen, return at the next negedge.
    task automatic cycle(input bit s, input bit m, input bit r);
        bus.btn_step = s;
        bus.btn_mode = m;
        rst          = r;
        @(posedge clk);
        model_edge(s, m, r);
        @(negedge clk);
    endtask

    function automatic logic [3:0] outs();
        return {bus.mode, bus.pulse, bus.step_db, bus.mode_db};
    endfunction

    function automatic logic [3:0] expv();
        return {e_mode, e_pulse, e_sdb, e_mdb};
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 1);
            checks++;
            if (outs() !== 4'b0000) $display("FAIL reset_clear cyc=%0d got=%b want=0000", i, outs());
            else passed++;
        end
        for (int i = 1; i <= 8; i++) begin
            cycle(1, 1, 0);
            checks++;
            if (outs() !== expv()) $display("FAIL reset_model edge=%0d got=%b want=%b", i, outs(), expv());
            else passed++;
            if (i == 5) begin
                checks++;
                if (bus.mode_db !== 1'b0) $display("FAIL reset_early edge=5 mode_db=%b want=0", bus.mode_db);
                else passed++;
            end
            if (i == 6) begin
                checks++;
                if ({bus.mode, bus.mode_db} !== 2'b11)
                    $display("FAIL reset_accept edge=6 mode,mode_db=%b%b want=11", bus.mode, bus.mode_db);
                else passed++;
            end
        end
        for (int i = 0; i < 8; i++) begin
            cycle(0, 0, 0);
            checks++;
            if (outs() !== expv()) $display("FAIL reset_release cyc=%0d got=%b want=%b", i, outs(), expv());
            else passed++;
        end
    endtask

    task automatic test_bounce();
        logic [13:0] pat;
        pat = 14'b11101110000000;
        for (int i = 0; i < 14; i++) begin
            cycle(pat[13-i], 0, 0);
            checks++;
            if (outs() !== expv() || bus.step_db !== 1'b0 || bus.pulse !== 1'b0 || bus.mode !== 1'b1)
                $display("FAIL bounce cyc=%0d got=%b want=%b (step_db,pulse 0)", i, outs(), expv());
            else passed++;
        end
    endtask

    task automatic test_clean_press();
        int npulse;
        npulse = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1, 0, 0);
            if (bus.pulse === 1'b1) npulse++;
            checks++;
            if (outs() !== expv() || bus.pulse !== (i == 5) || bus.step_db !== (i >= 5))
                $display("FAIL press_hold edge=%0d got=%b want=%b", i, outs(), expv());
            else passed++;
        end
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 0);
            if (bus.pulse === 1'b1) npulse++;
            checks++;
            if (outs() !== expv() || bus.pulse !== 1'b0 || bus.step_db !== (i < 5))
                $display("FAIL press_release edge=%0d got=%b want=%b", i, outs(), expv());
            else passed++;
        end
        checks++;
        if (npulse != 1) $display("FAIL press_count pulses=%0d want=1", npulse);
        else passed++;
    endtask

    task automatic test_mode_toggle();
        bit base, want;
        for (int p = 0; p < 2; p++) begin
            base = (p == 0);
            for (int i = 0; i < 16; i++) begin
                cycle(0, i < 8, 0);
                want = (i >= 5) ? !base : base;
                checks++;
                if (outs() !== expv() || bus.mode !== want || bus.pulse !== 1'b0)
                    $display("FAIL mode_toggle press=%0d cyc=%0d got=%b want mode=%b model=%b",
                             p, i, outs(), want, expv());
                else passed++;
            end
        end
    endtask

    task automatic test_auto();
        for (int i = 0; i < 16; i++) begin
            cycle(0, i < 8, 0);
            checks++;
            if (outs() !== expv() || bus.mode !== (i < 5))
                $display("FAIL auto_enter cyc=%0d got=%b want=%b", i, outs(), expv());
            else passed++;
        end
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 16; i++) begin
                cycle(i < 8, 0, 0);
                checks++;
                if (outs() !== expv() || bus.pulse !== 1'b0 || bus.mode !== 1'b0 ||
                    bus.step_db !== (i >= 5 && i < 13))
                    $display("FAIL auto_press p=%0d cyc=%0d got=%b want=%b", p, i, outs(), expv());
                else passed++;
            end
        end
    endtask

    task automatic test_simultaneous();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 16; i++) begin
                cycle(i < 8, i < 8, 0);
                checks++;
                if (outs() !== expv() ||
                    bus.mode !== ((r == 0) ? (i >= 5) : (i < 5)) ||
                    bus.pulse !== (r == 1 && i == 5))
                    $display("FAIL simultaneous r=%0d cyc=%0d got=%b want=%b", r, i, outs(), expv());
                else passed++;
            end
        end
    endtask

    task automatic test_random();
        bit s, m, r;
        int sl, ml;
        s = 0; m = 0; sl = 0; ml = 0;
        for (int i = 0; i < 3000; i++) begin
            if (sl == 0) begin s = !s; sl = $urandom_range(1, 8); end
            if (ml == 0) begin m = !m; ml = $urandom_range(1, 9); end
            sl--; ml--;
            r = ($urandom_range(0, 199) == 0);
            cycle(s, m, r);
            checks++;
            if (outs() !== expv())
                $display("FAIL random cyc=%0d s=%b m=%b rst=%b got=%b want=%b", i, s, m, r, outs(), expv());
            else passed++;
        end
    endtask

    initial begin
        bus.btn_step = 1'b0;
        bus.btn_mode = 1'b0;
        @(negedge clk);
        test_reset();
        test_bounce();
        test_clean_press();
        test_mode_toggle();
        test_auto();
        test_simultaneous();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
